// File: rtl/clk_div_pkg.sv
// Shared constants and types for the multi-channel clock divider.
// Imported by the channel and top modules.
package clk_div_pkg;

    localparam int BASE_CLK_HZ  = 1000;
    localparam int CNT_W_DEF    = 16;
    localparam int DEF_HALF_DEF = 2;

    // What a channel does on the coming clock edge, ignoring sync.
    typedef enum logic [1:0] {
        EV_HOLD      = 2'd0,
        EV_COUNT     = 2'd1,
        EV_WRAP_RISE = 2'd2,
        EV_WRAP_FALL = 2'd3
    } chan_ev_e;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: half-period counter, square wave, rising-edge tick,
// and a shadow half-period that is only applied at the end of a full period.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int DEF_HALF = DEF_HALF_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] half,
    input  logic             load,
    input  logic             sync,
    output logic             clk_out,
    output logic             tick
);

    localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEF_HALF);
    localparam logic [CNT_W-1:0] ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    // A programmed half-period of 0 behaves as 1 (divide by two).
    function automatic logic [CNT_W-1:0] eff_half(input logic [CNT_W-1:0] h);
        return (h == ZERO) ? ONE : h;
    endfunction

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] active_r;
    logic [CNT_W-1:0] shadow_r;
    logic             pend_r;
    logic             clk_out_r;
    logic             tick_r;

    logic [CNT_W-1:0] cnt_s;
    logic [CNT_W-1:0] active_s;
    logic [CNT_W-1:0] shadow_s;
    logic             pend_s;
    logic             clk_out_s;
    logic             tick_s;
    logic [CNT_W-1:0] last_s;
    chan_ev_e         ev_s;

    assign last_s = eff_half(active_r) - ONE;

    // Classify the coming edge; >= keeps a lowered ratio from overrunning.
    always_comb begin
        if (!en) begin
            ev_s = EV_HOLD;
        end else if (cnt_r >= last_s) begin
            ev_s = clk_out_r ? EV_WRAP_FALL : EV_WRAP_RISE;
        end else begin
            ev_s = EV_COUNT;
        end
    end

    // Next-state for counter, wave, tick and the active/shadow ratio pair.
    always_comb begin
        cnt_s     = cnt_r;
        clk_out_s = clk_out_r;
        tick_s    = 1'b0;
        active_s  = active_r;
        shadow_s  = shadow_r;
        pend_s    = pend_r;
        if (sync) begin
            cnt_s     = ZERO;
            clk_out_s = 1'b0;
            if (load) begin
                active_s = half;
                shadow_s = half;
            end else if (pend_r) begin
                active_s = shadow_r;
            end else begin
                active_s = active_r;
            end
            pend_s = 1'b0;
        end else begin
            case (ev_s)
                EV_COUNT: begin
                    cnt_s = cnt_r + ONE;
                end
                EV_WRAP_RISE: begin
                    cnt_s     = ZERO;
                    clk_out_s = 1'b1;
                    tick_s    = 1'b1;
                end
                EV_WRAP_FALL: begin
                    cnt_s     = ZERO;
                    clk_out_s = 1'b0;
                end
                default: begin
                    cnt_s = cnt_r;
                end
            endcase
            // End of a full period is the only point a new ratio may take over.
            if (ev_s == EV_WRAP_FALL) begin
                if (load) begin
                    active_s = half;
                    shadow_s = half;
                end else if (pend_r) begin
                    active_s = shadow_r;
                end else begin
                    active_s = active_r;
                end
                pend_s = 1'b0;
            end else if (load) begin
                shadow_s = half;
                pend_s   = 1'b1;
            end else begin
                pend_s = pend_r;
            end
        end
    end

    // Channel state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r     <= ZERO;
            clk_out_r <= 1'b0;
            tick_r    <= 1'b0;
            active_r  <= DEF_H;
            shadow_r  <= DEF_H;
            pend_r    <= 1'b0;
        end else begin
            cnt_r     <= cnt_s;
            clk_out_r <= clk_out_s;
            tick_r    <= tick_s;
            active_r  <= active_s;
            shadow_r  <= shadow_s;
            pend_r    <= pend_s;
        end
    end

    assign clk_out = clk_out_r;
    assign tick    = tick_r;

endmodule

// File: rtl/clk_div_multi.sv
// NCH independent programmable clock dividers sharing one system clock;
// the only cross-channel coupling is the common phase-sync strobe.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NCH      = 2,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int DEF_HALF = DEF_HALF_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       en,
    input  logic [NCH*CNT_W-1:0] div_half,
    input  logic [NCH-1:0]       load,
    input  logic                 sync,
    output logic [NCH-1:0]       clk_out,
    output logic [NCH-1:0]       tick
);

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        clk_div_chan #(
            .CNT_W    (CNT_W),
            .DEF_HALF (DEF_HALF)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .en      (en[g]),
            .half    (div_half[g*CNT_W +: CNT_W]),
            .load    (load[g]),
            .sync    (sync),
            .clk_out (clk_out[g]),
            .tick    (tick[g])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: expected per-cycle {clk_out,tick} of both
// channels are queued from the stimulus plan and popped after every clock edge.
module tb_clk_div_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  en;
    logic [31:0] div_half;
    logic [1:0]  load;
    logic        sync;
    logic [1:0]  clk_out;
    logic [1:0]  tick;

    typedef struct packed {
        logic c;
        logic t;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    clk_div_multi #(
        .NCH      (2),
        .CNT_W    (16),
        .DEF_HALF (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div_half (div_half),
        .load     (load),
        .sync     (sync),
        .clk_out  (clk_out),
        .tick     (tick)
    );

    always #500 clk = ~clk;

    initial begin
        #60000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Queue n entries of a square wave with lo zeros then hi ones, tick on the first one.
    task automatic push_run(input int ch, input int lo, input int hi, input int off, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            automatic int p = (i + off) % (lo + hi);
            e.c = (p >= lo);
            e.t = (p == lo);
            if (ch == 0) q0.push_back(e);
            else         q1.push_back(e);
        end
    endtask

    task automatic push_one(input int ch, input logic c, input logic t);
        exp_t e;
        e.c = c;
        e.t = t;
        if (ch == 0) q0.push_back(e);
        else         q1.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e0, e1;
        rst = 1'b1; en = 2'b00; load = 2'b00; sync = 1'b0;
        div_half = {16'd2, 16'd2};
        repeat (2) cyc();
        n_tests++;
        if ({clk_out, tick} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_hold: got %b want 0000", {clk_out, tick});
        end
        rst = 1'b0; en = 2'b11;
        repeat (3) cyc();
        n_tests++;
        if (clk_out !== 2'b11) begin
            n_fail++;
            $display("FAIL pre_reset_run: got clk_out=%b want 11", clk_out);
        end
        #200;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({clk_out, tick} !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_reset: got %b want 0000", {clk_out, tick});
        end
        @(negedge clk);
        rst = 1'b0;
        q0.delete(); q1.delete();
        push_run(0, 2, 2, 1, 12);
        push_run(1, 2, 2, 1, 12);
        for (int i = 0; i < 12; i++) begin
            cyc();
            e0 = q0.pop_front(); e1 = q1.pop_front();
            n_tests++;
            if ({clk_out[1], tick[1], clk_out[0], tick[0]} !== {e1, e0}) begin
                n_fail++;
                $display("FAIL reset_run cyc %0d: got %b want %b", i,
                         {clk_out[1], tick[1], clk_out[0], tick[0]}, {e1, e0});
            end
        end
    endtask

    task automatic test_load_mid_period();
        exp_t e0, e1;
        q0.delete(); q1.delete();
        sync = 1'b1; en = 2'b11;
        push_run(0, 2, 2, 0, 4);
        push_run(0, 5, 5, 0, 15);
        push_run(1, 2, 2, 0, 19);
        for (int i = 0; i < 19; i++) begin
            cyc();
            e0 = q0.pop_front(); e1 = q1.pop_front();
            n_tests++;
            if ({clk_out[1], tick[1], clk_out[0], tick[0]} !== {e1, e0}) begin
                n_fail++;
                $display("FAIL load_mid cyc %0d: got %b want %b", i,
                         {clk_out[1], tick[1], clk_out[0], tick[0]}, {e1, e0});
            end
            sync = 1'b0;
            load = (i == 2) ? 2'b01 : 2'b00;
            if (i == 2) div_half[15:0] = 16'd5;
        end
        load = 2'b00;
    endtask

    task automatic test_zero_one();
        exp_t e0, e1;
        q0.delete(); q1.delete();
        div_half = 32'd0; load = 2'b11;
        cyc();
        load = 2'b00; sync = 1'b1;
        push_run(0, 1, 1, 0, 16);
        push_run(1, 1, 1, 0, 16);
        for (int i = 0; i < 16; i++) begin
            cyc();
            e0 = q0.pop_front(); e1 = q1.pop_front();
            n_tests++;
            if ({clk_out[1], tick[1], clk_out[0], tick[0]} !== {e1, e0}) begin
                n_fail++;
                $display("FAIL zero_one cyc %0d: got %b want %b", i,
                         {clk_out[1], tick[1], clk_out[0], tick[0]}, {e1, e0});
            end
            sync = 1'b0;
            if (i == 7) begin
                load = 2'b11;
                div_half = {16'd1, 16'd1};
            end else begin
                load = 2'b00;
            end
        end
        load = 2'b00;
    endtask

    task automatic test_sync();
        exp_t e0, e1;
        q0.delete(); q1.delete();
        en = 2'b00; load = 2'b11; div_half = {16'd4, 16'd3};
        cyc();
        load = 2'b00;
        cyc();
        n_tests++;
        if (tick !== 2'b00) begin
            n_fail++;
            $display("FAIL disabled_tick: got %b want 00", tick);
        end
        sync = 1'b1; en = 2'b11;
        push_run(0, 3, 3, 0, 13);
        push_run(0, 3, 3, 0, 17);
        push_run(1, 4, 4, 0, 13);
        push_run(1, 4, 4, 0, 17);
        for (int i = 0; i < 30; i++) begin
            cyc();
            e0 = q0.pop_front(); e1 = q1.pop_front();
            n_tests++;
            if ({clk_out[1], tick[1], clk_out[0], tick[0]} !== {e1, e0}) begin
                n_fail++;
                $display("FAIL sync cyc %0d: got %b want %b", i,
                         {clk_out[1], tick[1], clk_out[0], tick[0]}, {e1, e0});
            end
            sync = (i == 12);
        end
        sync = 1'b0;
    endtask

    task automatic test_enable_hold();
        exp_t e0, e1;
        q0.delete(); q1.delete();
        sync = 1'b1; en = 2'b11;
        push_run(0, 3, 3, 0, 5);
        for (int k = 0; k < 8; k++) push_one(0, 1'b1, 1'b0);
        push_run(0, 2, 2, 0, 12);
        push_run(1, 4, 4, 0, 25);
        for (int i = 0; i < 25; i++) begin
            cyc();
            e0 = q0.pop_front(); e1 = q1.pop_front();
            n_tests++;
            if ({clk_out[1], tick[1], clk_out[0], tick[0]} !== {e1, e0}) begin
                n_fail++;
                $display("FAIL enable_hold cyc %0d: got %b want %b", i,
                         {clk_out[1], tick[1], clk_out[0], tick[0]}, {e1, e0});
            end
            sync = 1'b0;
            en   = (i >= 4 && i < 11) ? 2'b10 : 2'b11;
            load = (i == 6) ? 2'b01 : 2'b00;
            if (i == 6) div_half[15:0] = 16'd2;
        end
        load = 2'b00;
    endtask

    task automatic test_coincident();
        exp_t e0, e1;
        q0.delete(); q1.delete();
        en = 2'b00; load = 2'b01; div_half = {16'd4, 16'd7};
        cyc();
        en = 2'b11; sync = 1'b1; load = 2'b01; div_half = {16'd4, 16'd3};
        push_run(0, 3, 3, 0, 6);
        push_run(0, 2, 2, 0, 8);
        push_run(0, 2, 2, 0, 16);
        push_run(1, 4, 4, 0, 14);
        push_run(1, 6, 6, 0, 16);
        for (int i = 0; i < 30; i++) begin
            cyc();
            e0 = q0.pop_front(); e1 = q1.pop_front();
            n_tests++;
            if ({clk_out[1], tick[1], clk_out[0], tick[0]} !== {e1, e0}) begin
                n_fail++;
                $display("FAIL coincident cyc %0d: got %b want %b", i,
                         {clk_out[1], tick[1], clk_out[0], tick[0]}, {e1, e0});
            end
            sync = (i == 13);
            load = (i == 5) ? 2'b01 : ((i == 13) ? 2'b10 : 2'b00);
            if (i == 5)  div_half[15:0]  = 16'd2;
            if (i == 13) div_half[31:16] = 16'd6;
        end
        sync = 1'b0;
        load = 2'b00;
    endtask

    initial begin
        rst = 1'b1; en = 2'b00; load = 2'b00; sync = 1'b0; div_half = 32'd0;
        test_reset();
        test_load_mid_period();
        test_zero_one();
        test_sync();
        test_enable_hold();
        test_coincident();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
